can_bit_transmitter: RTL

- Bit-level transmit engine of the CAN controller's timing module.
- Accepts frame bits one at a time over a valid/ready handshake and drives the bus TX line with one nominal bit time per bit.
- Inserts stuff bits automatically and flags bit-monitoring mismatches against the bus RX line at the sample point.
- Sits between the frame/protocol layer and the transceiver pins. It is the transmit-side counterpart of the RX edge/synchronisation logic.

---
 rtl/can_bit_transmitter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/can_bit_transmitter.sv
// CAN bit-level transmit engine: one nominal bit time per accepted bit,
// automatic stuff-bit insertion and bit monitoring at the sample point.
module can_bit_transmitter #(
    parameter int BRP   = 4,
    parameter int TSEG1 = 13,
    parameter int TSEG2 = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tx_valid,
    input  logic tx_bit,
    output logic tx_ready,
    input  logic stuff_en,
    input  logic rx_in,
    output logic tx_out,
    output logic bit_start,
    output logic sample_point,
    output logic stuff_active,
    output logic bit_error,
    output logic busy
);

    localparam int NTQ = 1 + TSEG1 + TSEG2;

    localparam logic [5:0] TQ_LAST  = 6'(BRP - 1);
    localparam logic [4:0] SEG_LAST = 5'(NTQ - 1);
    localparam logic [4:0] SEG_SP   = 5'(1 + TSEG1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STUFF
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] tq_cnt;
    logic [4:0] seg_cnt;
    logic [2:0] run;
    logic [2:0] run_base;
    logic       last_bit;
    logic       slot_last;
    logic       stuff_due;
    logic       handshake;

    assign slot_last = (state != IDLE) && (tq_cnt == TQ_LAST) && (seg_cnt == SEG_LAST);
    assign stuff_due = slot_last && (run == 3'd5) && stuff_en;
    assign handshake = tx_valid && tx_ready;

    // A full run that was not stuffed restarts counting from zero.
    assign run_base  = (run == 3'd5 && !stuff_en) ? 3'd0 : run;

    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // only takes effect at a rising edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) state_next = DATA;
            end
            DATA, STUFF: begin
                if (slot_last) begin
                    if (stuff_due)      state_next = STUFF;
                    else if (handshake) state_next = DATA;
                    else                state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default first, so no path through this
    // block can infer a latch.
    always_comb begin
        tx_ready     = 1'b0;
        bit_start    = 1'b0;
        sample_point = 1'b0;
        stuff_active = 1'b0;
        busy         = 1'b0;
        if (state == IDLE) begin
            tx_ready = 1'b1;
        end else begin
            busy         = 1'b1;
            tx_ready     = slot_last && !stuff_due;
            bit_start    = (tq_cnt == 6'd0) && (seg_cnt == 5'd0);
            sample_point = (tq_cnt == 6'd0) && (seg_cnt == SEG_SP);
            stuff_active = (state == STUFF);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_out    <= 1'b1;
            last_bit  <= 1'b0;
            run       <= 3'd0;
            tq_cnt    <= 6'd0;
            seg_cnt   <= 5'd0;
            bit_error <= 1'b0;
        end else begin
            bit_error <= sample_point && (rx_in != tx_out);

            if (state == IDLE || slot_last) begin
                tq_cnt  <= 6'd0;
                seg_cnt <= 5'd0;
            end else if (tq_cnt == TQ_LAST) begin
                tq_cnt  <= 6'd0;
                seg_cnt <= seg_cnt + 5'd1;
            end else begin
                tq_cnt  <= tq_cnt + 6'd1;
            end

            if (state == IDLE) begin
                if (handshake) begin
                    tx_out   <= tx_bit;
                    last_bit <= tx_bit;
                    run      <= 3'd1;
                end
            end else if (slot_last) begin
                if (stuff_due) begin
                    tx_out   <= ~last_bit;
                    last_bit <= ~last_bit;
                    run      <= 3'd1;
                end else if (handshake) begin
                    tx_out   <= tx_bit;
                    last_bit <= tx_bit;
                    run      <= (tx_bit == last_bit) ? run_base + 3'd1 : 3'd1;
                end else begin
                    tx_out <= 1'b1;
                    run    <= 3'd0;
                end
            end
        end
    end

endmodule
